// File: rtl/mux_arb_pkg.sv
// Shared constants for the two-requester mux arbiter: state encoding and default sizing.
package mux_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GNT0 = 2'd1;
    localparam logic [1:0] ST_GNT1 = 2'd2;

    localparam int unsigned HOLD_MAX_DEF = 4;
    localparam int unsigned CNT_W_DEF    = 8;

endpackage

// File: rtl/mux_arbiter_mux_w.sv
// W-bit 2:1 combinational mux used for the arbiter's shared data path.
module mux_w #(
    parameter int unsigned W = 1
) (
    input  logic [W-1:0] I0,
    input  logic [W-1:0] I1,
    input  logic         S,
    output logic [W-1:0] Y
);

    assign Y = S ? I1 : I0;

endmodule

// File: rtl/mux_arbiter.sv
// Two-requester arbiter with bounded hold time driving a shared W-bit 2:1 mux.
// Define MUX_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins) instead of round-robin.
module mux_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned W        = 1,
    parameter int unsigned HOLD_MAX = HOLD_MAX_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         R0,
    input  logic         R1,
    input  logic [W-1:0] D0,
    input  logic [W-1:0] D1,
    output logic         G0,
    output logic         G1,
    output logic         S,
    output logic [W-1:0] Y,
    output logic         Busy
);

    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(HOLD_MAX - 1);

    logic [1:0]       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             s_nxt;
`ifndef MUX_ARB_FIXED_PRIO_EN
    logic             last, last_nxt;
`endif

    // Next-state decision plus the registered-output next values.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        s_nxt     = S;
`ifndef MUX_ARB_FIXED_PRIO_EN
        last_nxt  = last;
`endif
        case (state)
            ST_IDLE: begin
                if (R0 && R1) begin
`ifdef MUX_ARB_FIXED_PRIO_EN
                    state_nxt = ST_GNT0;
`else
                    state_nxt = last ? ST_GNT0 : ST_GNT1;
`endif
                end else if (R0) begin
                    state_nxt = ST_GNT0;
                end else if (R1) begin
                    state_nxt = ST_GNT1;
                end
            end
            ST_GNT0: begin
                if (!R0) begin
                    state_nxt = R1 ? ST_GNT1 : ST_IDLE;
                end else if (R1 && (cnt == CNT_TOP)) begin
                    state_nxt = ST_GNT1;
                end else if (cnt != CNT_TOP) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_GNT1: begin
                if (!R1) begin
                    state_nxt = R0 ? ST_GNT0 : ST_IDLE;
`ifdef MUX_ARB_FIXED_PRIO_EN
                end else if (R0) begin
`else
                end else if (R0 && (cnt == CNT_TOP)) begin
`endif
                    state_nxt = ST_GNT0;
                end else if (cnt != CNT_TOP) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Entering a grant state restarts the hold count and repoints the mux.
        if (state_nxt != state) begin
            cnt_nxt = '0;
        end
        if (state_nxt == ST_GNT0) begin
            s_nxt = 1'b0;
        end else if (state_nxt == ST_GNT1) begin
            s_nxt = 1'b1;
        end
`ifndef MUX_ARB_FIXED_PRIO_EN
        if (state_nxt == ST_GNT0) begin
            last_nxt = 1'b0;
        end else if (state_nxt == ST_GNT1) begin
            last_nxt = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            S     <= 1'b0;
            G0    <= 1'b0;
            G1    <= 1'b0;
            Busy  <= 1'b0;
`ifndef MUX_ARB_FIXED_PRIO_EN
            last  <= 1'b1;
`endif
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            S     <= s_nxt;
            G0    <= (state_nxt == ST_GNT0);
            G1    <= (state_nxt == ST_GNT1);
            Busy  <= (state_nxt == ST_GNT0) || (state_nxt == ST_GNT1);
`ifndef MUX_ARB_FIXED_PRIO_EN
            last  <= last_nxt;
`endif
        end
    end

    mux_w #(.W(W)) u_mux (
        .I0 (D0),
        .I1 (D1),
        .S  (S),
        .Y  (Y)
    );

endmodule

// File: tb/tb_mux_arbiter.sv
// Directed self-checking bench for mux_arbiter (HOLD_MAX=4, W=4).
module tb_mux_arbiter;

    localparam int unsigned W = 4;

    logic         clk;
    logic         reset;
    logic         R0, R1;
    logic [W-1:0] D0, D1;
    logic         G0, G1, S, Busy;
    logic [W-1:0] Y;

    int checks;
    int failures;

    mux_arbiter #(.W(W), .HOLD_MAX(4), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .R0    (R0),
        .R1    (R1),
        .D0    (D0),
        .D1    (D1),
        .G0    (G0),
        .G1    (G1),
        .S     (S),
        .Y     (Y),
        .Busy  (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected outputs for one step: grant owner (0 none, 1 req0, 2 req1), select.
    task automatic chk_all(input string tag, input int owner, input logic s_exp);
        chk({tag, ".G0"},   32'(G0),   32'(owner == 1));
        chk({tag, ".G1"},   32'(G1),   32'(owner == 2));
        chk({tag, ".Busy"}, 32'(Busy), 32'(owner != 0));
        chk({tag, ".S"},    32'(S),    32'(s_exp));
        chk({tag, ".Y"},    32'(Y),    s_exp ? 32'(D1) : 32'(D0));
    endtask

    initial begin
        int owner;
        checks   = 0;
        failures = 0;
        D0 = 4'h5;
        D1 = 4'hA;

        // Reset held for two edges with both requesting.
        reset = 1'b1; R0 = 1'b1; R1 = 1'b1;
        tick(); chk_all("rst0", 0, 1'b0);
        tick(); chk_all("rst1", 0, 1'b0);
        reset = 1'b0;

        // Tie from reset: alternate owners under the hold limit.
        for (int i = 0; i < 12; i++) begin
            tick();
`ifdef MUX_ARB_FIXED_PRIO_EN
            owner = ((i % 5) < 4) ? 1 : 2;
`else
            owner = (((i / 4) % 2) == 0) ? 1 : 2;
`endif
            chk_all($sformatf("tie%0d", i), owner, owner == 2);
        end

        // Handoff from GNT0 straight to GNT1, then release to IDLE.
        R0 = 1'b0;
        tick(); chk_all("handoff", 2, 1'b1);
        R1 = 1'b0;
        tick(); chk_all("idle_hold_s", 0, 1'b1);

        // Lone requester keeps the grant; Y tracks D1 while S=1.
        R1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            D1 = 4'(i);
            tick();
            chk_all($sformatf("lone%0d", i), 2, 1'b1);
        end

        // Back to IDLE, regrant GNT1 and reset at cnt=2.
        R1 = 1'b0;
        tick(); chk_all("idle2", 0, 1'b1);
        R1 = 1'b1;
        tick(); chk_all("g1_c0", 2, 1'b1);
        tick(); chk_all("g1_c1", 2, 1'b1);
        tick(); chk_all("g1_c2", 2, 1'b1);
        reset = 1'b1; R0 = 1'b1; R1 = 1'b1;
        tick(); chk_all("midrst", 0, 1'b0);
        reset = 1'b0;
        tick(); chk_all("post_rst", 1, 1'b0);

        // After serving requester 0, a fresh tie goes to requester 1 (round-robin).
        R0 = 1'b0; R1 = 1'b0;
        tick(); chk_all("idle3", 0, 1'b0);
        R0 = 1'b1; R1 = 1'b1;
        tick();
`ifdef MUX_ARB_FIXED_PRIO_EN
        chk_all("tie_after_g0", 1, 1'b0);
`else
        chk_all("tie_after_g0", 2, 1'b1);
`endif

        // Request dropped before its grant is not remembered.
        R0 = 1'b0; R1 = 1'b0;
        tick();
        R0 = 1'b1;
        tick();
        R0 = 1'b0;
        tick();
        chk_all("drop_pulse", 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
